tournament_chooser: RTL

//  Controller for the tournament predictor's chooser table: 2-bit saturating counters held in the
//  256x2 1W/1R OpenRAM chooser macro. Sits between fetch/predict (upstream) and the macro
//  (downstream), and drives both macro ports.
//  - Initialises the macro after reset (the macro has no reset).
//  - Serves one chooser lookup per cycle.
//  - Performs saturating counter updates on branch resolution.
//  - Forwards same-cycle writes to lookups, because the macro's write lands one edge late.

---
 rtl/tournament_chooser_pkg.sv | 19 +
 rtl/tournament_chooser_if.sv | 30 +++
 rtl/tournament_chooser.sv | 119 +++++++++++
 3 files changed

// File: rtl/tournament_chooser_pkg.sv
// Shared types, sizes and counter helpers for the tournament predictor chooser table.
package tournament_pkg;

  typedef logic [1:0] chooser_ctr_t;

  localparam int unsigned CHOOSER_IDX_W = 8;
  localparam chooser_ctr_t CTR_INIT = 2'b01;

  typedef enum logic {INIT, RUN} chooser_state_t;

  function automatic chooser_ctr_t sat_inc(chooser_ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic chooser_ctr_t sat_dec(chooser_ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/tournament_chooser_if.sv
// Lookup and update channels between fetch/predict (master) and the chooser controller (slave).
interface tournament_chooser_if #(
  parameter int unsigned PC_W = 32
) ();
  import tournament_pkg::*;

  logic            pred_valid;
  logic [PC_W-1:0] pred_pc;
  logic            pred_ready;
  logic            pred_resp_valid;
  chooser_ctr_t    pred_ctr;
  logic            pred_use_global;

  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  chooser_ctr_t    upd_ctr;
  logic            upd_local_correct;
  logic            upd_global_correct;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_ctr, upd_local_correct, upd_global_correct,
    input  pred_ready, pred_resp_valid, pred_ctr, pred_use_global
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_ctr, upd_local_correct, upd_global_correct,
    output pred_ready, pred_resp_valid, pred_ctr, pred_use_global
  );

endinterface

// File: rtl/tournament_chooser.sv
// Chooser table controller: init sweep, lookups, saturating updates and write-to-read bypass.
// Define TOURNAMENT_CHOOSER_PERF_EN to build the perf_global_cnt / perf_write_cnt counters.
module tournament_chooser
  import tournament_pkg::*;
#(
  parameter int unsigned  IDX_W    = CHOOSER_IDX_W,
  parameter int unsigned  PC_W     = 32,
  parameter chooser_ctr_t CTR_INIT = tournament_pkg::CTR_INIT
) (
  input  logic                 clk,
  input  logic                 rst,
  tournament_chooser_if.slave  bus,
  output logic                 init_done,
  output logic                 sram_wcsb,
  output logic [IDX_W-1:0]     sram_waddr,
  output chooser_ctr_t         sram_wdata,
  output logic                 sram_rcsb,
  output logic [IDX_W-1:0]     sram_raddr,
  input  chooser_ctr_t         sram_rdata,
  output logic [31:0]          perf_global_cnt,
  output logic [31:0]          perf_write_cnt
);

  chooser_state_t   state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             resp_valid_q;
  logic             byp_hit_q;
  chooser_ctr_t     byp_data_q;

  logic [PC_W-1:0]  pred_pc, upd_pc;
  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic             running, accept, upd_en, wr_en;
  chooser_ctr_t     upd_nxt, resp_ctr;
  logic             unused_pc;

  assign pred_pc   = bus.pred_pc;
  assign upd_pc    = bus.upd_pc;
  assign pred_idx  = pred_pc[IDX_W+1:2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign unused_pc = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0], upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

  always_comb begin
    running = (state_q == RUN);
    accept  = running & bus.pred_valid;
    upd_en  = running & bus.upd_valid & (bus.upd_local_correct != bus.upd_global_correct);
    upd_nxt = bus.upd_global_correct ? sat_inc(bus.upd_ctr) : sat_dec(bus.upd_ctr);
    // A saturated counter would be rewritten with its own value, so skip the write.
    wr_en   = upd_en & (upd_nxt != bus.upd_ctr);
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    sram_wcsb  = 1'b1;
    sram_waddr = upd_idx;
    sram_wdata = upd_nxt;
    unique case (state_q)
      INIT: begin
        sram_wcsb  = 1'b0;
        sram_waddr = init_idx_q;
        sram_wdata = CTR_INIT;
        init_idx_d = init_idx_q + 1'b1;
        if (&init_idx_q) state_d = RUN;
      end
      RUN: begin
        sram_wcsb = ~wr_en;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      resp_valid_q <= 1'b0;
      byp_hit_q    <= 1'b0;
      byp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      resp_valid_q <= accept;
      // The macro returns the pre-write value when read and write hit the same edge.
      byp_hit_q    <= accept & wr_en & (upd_idx == pred_idx);
      byp_data_q   <= upd_nxt;
    end
  end

  assign sram_rcsb  = ~accept;
  assign sram_raddr = pred_idx;
  assign resp_ctr   = resp_valid_q ? (byp_hit_q ? byp_data_q : sram_rdata) : '0;

  assign bus.pred_ready      = running;
  assign bus.pred_resp_valid = resp_valid_q;
  assign bus.pred_ctr        = resp_ctr;
  assign bus.pred_use_global = resp_ctr[1];
  assign init_done           = running;

`ifdef TOURNAMENT_CHOOSER_PERF_EN
  logic [31:0] global_cnt_q, write_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      global_cnt_q <= '0;
      write_cnt_q  <= '0;
    end else begin
      if (resp_valid_q && resp_ctr[1]) global_cnt_q <= global_cnt_q + 32'd1;
      if (wr_en) write_cnt_q <= write_cnt_q + 32'd1;
    end
  end

  assign perf_global_cnt = global_cnt_q;
  assign perf_write_cnt  = write_cnt_q;
`else
  assign perf_global_cnt = '0;
  assign perf_write_cnt  = '0;
`endif

endmodule
